em_stage_reg: RTL and testbench
===============================

Name: em_stage_reg

Overview:
- E→M pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the E-stage ALU and consumes its `ao`/`overflow` results together with the E-stage instruction bundle.
- Converts ALU overflow into a precise exception code (Ov/AdEL/AdES), adds an alignment check, and suppresses register write-back for excepting instructions.
- Supports stall (hold), flush (bubble) and a valid bit for the M stage and CP0.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into `pc_m` on reset and flush.
- ALIGN_CHECK, 1, when 1 the block raises AdEL/AdES on misaligned lw/lh/lhu/sw/sh addresses.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; asserted when 0.
- stall_m  in  1  hold all M-stage registers.
- flush_m  in  1  replace the M-stage contents with a bubble (exception entry / eret).
- valid_e  in  1  E-stage slot holds a real instruction.
- instr_e  in  32  E-stage instruction word.
- pc_e  in  32  E-stage PC.
- ao_e  in  32  ALU result / memory address.
- overflow_e  in  1  ALU signed overflow for add/sub.
- rt_data_e  in  32  forwarded rt value (store data).
- a3_e  in  5  destination GPR.
- exccode_e  in  5  exception already carried from F/D/E; 0 means none.
- bd_e  in  1  instruction is in a branch delay slot.
- instr_m  out  32  registered instruction.
- pc_m  out  32  registered PC.
- ao_m  out  32  registered ALU result.
- rt_data_m  out  32  registered store data.
- a3_m  out  5  registered destination; 0 if excepting.
- exccode_m  out  5  registered exception code.
- bd_m  out  1  registered delay-slot flag.
- valid_m  out  1  M slot holds a real instruction.

Behaviour:
- Priority each edge: reset (reset==0) > flush_m > stall_m > load.
- Reset / flush state:
  - `instr_m`, `ao_m`, `rt_data_m`: 0.
  - `a3_m`, `exccode_m`, `bd_m`, `valid_m`: 0.
  - `pc_m`: RESET_PC.
- flush_m together with stall_m: flush wins.
- stall_m=1, flush_m=0: every output holds its value; inputs are ignored.
- Load: all outputs take their E-stage counterparts after one cycle. `exccode_m` and `a3_m` are computed as follows.
- Instruction classes, decoded from `instr_e[31:26]` and funct `[5:0]`:
  - OVF: add (0/0x20), sub (0/0x22), addi (0x08).
  - LOAD: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - STORE: sw 0x2B, sh 0x29, sb 0x28.
  - addu/subu/addiu never raise Ov.
- Derived exception code `new_exc`:
  - OVF & overflow_e → 12 (Ov).
  - LOAD & overflow_e → 4 (AdEL).
  - STORE & overflow_e → 5 (AdES).
  - ALIGN_CHECK=1:
    - lw with ao_e[1:0]≠0 → 4.
    - lh/lhu with ao_e[0]≠0 → 4.
    - sw with ao_e[1:0]≠0 → 5.
    - sh with ao_e[0]≠0 → 5.
  - Otherwise 0.
  - overflow_e is considered only for OVF/LOAD/STORE; it is ignored for all other classes.
- exccode priority: `exccode_m = (exccode_e≠0) ? exccode_e : new_exc`. The earliest-stage exception always wins.
- Write-back suppression: `a3_m = (final exccode ≠ 0) ? 0 : a3_e`.
- `ao_m` is stored unmodified even when excepting; CP0 uses it as BadVAddr for AdEL/AdES.
- valid_e=0 loads a bubble:
  - `instr_m`=0, `a3_m`=0, `exccode_m`=0, `valid_m`=0.
  - `pc_m`=pc_e and `bd_m`=bd_e, so the macroscopic PC stays correct.
- Latency: exactly 1 cycle from E to M when not stalled.
- No combinational path from any input to any output; all outputs are registered.
- Reset mid-stall or mid-flush: reset has priority; all outputs take their reset values on that edge.

Decomposition:
- Shared package `mips_pkg`:
  - opcode/funct localparams (OP_SPECIAL, OP_ADDI, OP_LW, ...).
  - exception codes EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_OV=12.
- One natural sub-module, `e_exc_detect`: purely combinational; takes instr_e, ao_e, overflow_e and produces `new_exc` (5 bits).
- The register/priority logic stays in em_stage_reg.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → all outputs 0 except pc_m=32'h0000_3000; valid_m=0.
- add overflow: instr_e=add $3,$1,$2 (0x00221820), overflow_e=1, a3_e=3, exccode_e=0 → next cycle exccode_m=12, a3_m=0, valid_m=1.
- Misaligned load: lw with ao_e=32'h0000_0002, overflow_e=0 → exccode_m=4, a3_m=0, ao_m=2. Same case with sh at ao_e=1 → exccode_m=5.
- Upstream exception priority: exccode_e=10 (RI), add with overflow_e=1 → exccode_m=10.
- Stall then flush: load addu (a3_e=5), then stall_m=1 for 3 cycles while inputs change → outputs constant. Then stall_m=1 and flush_m=1 together → bubble (instr_m=0, pc_m=32'h3000, valid_m=0).
- Bubble input: valid_e=0, pc_e=32'h0000_3010, bd_e=1 → instr_m=0, valid_m=0, pc_m=32'h3010, bd_m=1. addiu with overflow_e=1 → exccode_m=0, a3_m kept.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings and CP0 exception codes.
// Contents: localparams only. The E/M pipeline files import this package.
// Only the encodings the E->M exception logic decodes are listed here.
package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes, instr[5:0]
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_NONE   = 5'd0;
  localparam logic [4:0] EXC_ADEL   = 5'd4;
  localparam logic [4:0] EXC_ADES   = 5'd5;
  localparam logic [4:0] EXC_OV     = 5'd12;

endpackage

// File: rtl/em_stage_reg_if.sv
// E->M stage bundle: control, E-stage inputs and registered M-stage outputs.
// slave: the stage register (consumes E side, drives M side).
// master: the surrounding core (drives E side, observes M side).
interface em_stage_reg_if;

  logic        stall_m;
  logic        flush_m;
  logic        valid_e;
  logic [31:0] instr_e;
  logic [31:0] pc_e;
  logic [31:0] ao_e;
  logic        overflow_e;
  logic [31:0] rt_data_e;
  logic [4:0]  a3_e;
  logic [4:0]  exccode_e;
  logic        bd_e;

  logic [31:0] instr_m;
  logic [31:0] pc_m;
  logic [31:0] ao_m;
  logic [31:0] rt_data_m;
  logic [4:0]  a3_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic        valid_m;

  modport slave (
    input  stall_m, flush_m, valid_e, instr_e, pc_e, ao_e, overflow_e,
           rt_data_e, a3_e, exccode_e, bd_e,
    output instr_m, pc_m, ao_m, rt_data_m, a3_m, exccode_m, bd_m, valid_m
  );

  modport master (
    output stall_m, flush_m, valid_e, instr_e, pc_e, ao_e, overflow_e,
           rt_data_e, a3_e, exccode_e, bd_e,
    input  instr_m, pc_m, ao_m, rt_data_m, a3_m, exccode_m, bd_m, valid_m
  );

endinterface

// File: rtl/e_exc_detect.sv
// Combinational E-stage exception detector: Ov / AdEL / AdES from ALU flags and address.
// Ports: i_instr (instruction word), i_ao (ALU result/address), i_overflow, o_new_exc.
// Purely combinational; zero latency.
module e_exc_detect
  import mips_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [31:0] i_instr,
  input  logic [31:0] i_ao,
  input  logic        i_overflow,
  output logic [4:0]  o_new_exc
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_is_ovf;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_unused;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];
  // Only the opcode/funct fields and the low address bits matter here.
  assign w_unused = ^{i_instr[25:6], i_ao[31:2]};

  assign w_is_ovf   = ((w_op == OP_SPECIAL) && ((w_fn == FN_ADD) || (w_fn == FN_SUB)))
                    || (w_op == OP_ADDI);
  assign w_is_load  = (w_op == OP_LW) || (w_op == OP_LH) || (w_op == OP_LHU)
                    || (w_op == OP_LB) || (w_op == OP_LBU);
  assign w_is_store = (w_op == OP_SW) || (w_op == OP_SH) || (w_op == OP_SB);

  always_comb begin
    o_new_exc = EXC_NONE;
    if (w_is_ovf && i_overflow) begin
      o_new_exc = EXC_OV;
    end else if (w_is_load) begin
      // Address-calculation overflow on a load is an address error, not Ov.
      if (i_overflow) begin
        o_new_exc = EXC_ADEL;
      end else if (ALIGN_CHECK && (w_op == OP_LW) && (i_ao[1:0] != 2'b00)) begin
        o_new_exc = EXC_ADEL;
      end else if (ALIGN_CHECK && ((w_op == OP_LH) || (w_op == OP_LHU)) && i_ao[0]) begin
        o_new_exc = EXC_ADEL;
      end
    end else if (w_is_store) begin
      if (i_overflow) begin
        o_new_exc = EXC_ADES;
      end else if (ALIGN_CHECK && (w_op == OP_SW) && (i_ao[1:0] != 2'b00)) begin
        o_new_exc = EXC_ADES;
      end else if (ALIGN_CHECK && (w_op == OP_SH) && i_ao[0]) begin
        o_new_exc = EXC_ADES;
      end
    end
  end

endmodule

// File: rtl/em_stage_reg.sv
// E->M pipeline register with precise exception merge and write-back suppression.
// Ports: clk, reset (sync, active-low), bus (em_stage_reg_if.slave: stall/flush, E in, M out).
// Latency 1 cycle; priority reset > flush_m > stall_m (hold) > load.
module em_stage_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  em_stage_reg_if.slave  bus
);

  logic [4:0]  w_new_exc;
  logic [4:0]  w_exc_final;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_ao;
  logic [31:0] r_rt_data;
  logic [4:0]  r_a3;
  logic [4:0]  r_exccode;
  logic        r_bd;
  logic        r_valid;

  e_exc_detect #(
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_exc_detect (
    .i_instr    (bus.instr_e),
    .i_ao       (bus.ao_e),
    .i_overflow (bus.overflow_e),
    .o_new_exc  (w_new_exc)
  );

  // An exception raised in an earlier stage is older, so it wins.
  assign w_exc_final = (bus.exccode_e != EXC_NONE) ? bus.exccode_e : w_new_exc;

  always_ff @(posedge clk) begin
    if (!reset || bus.flush_m) begin
      r_instr   <= 32'd0;
      r_pc      <= RESET_PC;
      r_ao      <= 32'd0;
      r_rt_data <= 32'd0;
      r_a3      <= 5'd0;
      r_exccode <= EXC_NONE;
      r_bd      <= 1'b0;
      r_valid   <= 1'b0;
    end else if (!bus.stall_m) begin
      // pc/bd travel even with bubbles so CP0 always sees a correct EPC.
      r_pc      <= bus.pc_e;
      r_bd      <= bus.bd_e;
      // ao is kept unmodified on exceptions: it is BadVAddr for AdEL/AdES.
      r_ao      <= bus.ao_e;
      r_rt_data <= bus.rt_data_e;
      if (bus.valid_e) begin
        r_instr   <= bus.instr_e;
        r_exccode <= w_exc_final;
        r_a3      <= (w_exc_final != EXC_NONE) ? 5'd0 : bus.a3_e;
        r_valid   <= 1'b1;
      end else begin
        r_instr   <= 32'd0;
        r_exccode <= EXC_NONE;
        r_a3      <= 5'd0;
        r_valid   <= 1'b0;
      end
    end
  end

  assign bus.instr_m   = r_instr;
  assign bus.pc_m      = r_pc;
  assign bus.ao_m      = r_ao;
  assign bus.rt_data_m = r_rt_data;
  assign bus.a3_m      = r_a3;
  assign bus.exccode_m = r_exccode;
  assign bus.bd_m      = r_bd;
  assign bus.valid_m   = r_valid;

endmodule

// File: tb/tb_em_stage_reg.sv
// Testbench for em_stage_reg: directed cases plus randomized traffic vs. a behavioural model.
// Ports: none; instantiates em_stage_reg_if and drives it as the core would.
// Inputs change #1 after a rising edge; outputs are compared #1 after the next edge.
module tb_em_stage_reg;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  em_stage_reg_if bus ();

  em_stage_reg #(
    .RESET_PC    (RST_PC),
    .ALIGN_CHECK (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected M-stage contents
  logic [31:0] m_instr, m_pc, m_ao, m_rt;
  logic [4:0]  m_a3, m_exc;
  logic        m_bd, m_valid;
  bit          m_data_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Exception an instruction raises on its own, straight from the ISA rules.
  function automatic logic [4:0] exc_of(input logic [31:0] ins, input logic [31:0] addr,
                                        input logic ovf);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    int a  = int'(addr[1:0]);
    if ((op == 0 && (fn == 'h20 || fn == 'h22)) || op == 'h08) return ovf ? 5'd12 : 5'd0;
    if (op == 'h23 || op == 'h21 || op == 'h25 || op == 'h20 || op == 'h24) begin
      if (ovf) return 5'd4;
      if (op == 'h23 && (a % 4) != 0) return 5'd4;
      if ((op == 'h21 || op == 'h25) && (a % 2) != 0) return 5'd4;
      return 5'd0;
    end
    if (op == 'h2B || op == 'h29 || op == 'h28) begin
      if (ovf) return 5'd5;
      if (op == 'h2B && (a % 4) != 0) return 5'd5;
      if (op == 'h29 && (a % 2) != 0) return 5'd5;
      return 5'd0;
    end
    return 5'd0;
  endfunction

  task automatic model_clear();
    m_instr = 0; m_pc = RST_PC; m_ao = 0; m_rt = 0;
    m_a3 = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_data_known = 1;
  endtask

  // Advance model with current inputs, clock the DUT, compare every output.
  task automatic cycle();
    if (!reset || bus.flush_m) begin
      model_clear();
    end else if (!bus.stall_m) begin
      m_pc = bus.pc_e;
      m_bd = bus.bd_e;
      if (bus.valid_e) begin
        m_instr = bus.instr_e;
        m_exc   = (bus.exccode_e != 0) ? bus.exccode_e
                                        : exc_of(bus.instr_e, bus.ao_e, bus.overflow_e);
        m_a3    = (m_exc != 0) ? 5'd0 : bus.a3_e;
        m_valid = 1;
        m_ao    = bus.ao_e;
        m_rt    = bus.rt_data_e;
        m_data_known = 1;
      end else begin
        m_instr = 0; m_exc = 0; m_a3 = 0; m_valid = 0;
        m_data_known = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("instr_m", bus.instr_m, m_instr);
    chk("pc_m", bus.pc_m, m_pc);
    chk("a3_m", {27'd0, bus.a3_m}, {27'd0, m_a3});
    chk("exccode_m", {27'd0, bus.exccode_m}, {27'd0, m_exc});
    chk("bd_m", {31'd0, bus.bd_m}, {31'd0, m_bd});
    chk("valid_m", {31'd0, bus.valid_m}, {31'd0, m_valid});
    if (m_data_known) begin
      chk("ao_m", bus.ao_m, m_ao);
      chk("rt_data_m", bus.rt_data_m, m_rt);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] ao, input logic ovf, input logic [4:0] a3,
                       input logic [4:0] exc, input logic bd);
    bus.valid_e = v; bus.instr_e = ins; bus.pc_e = pc; bus.ao_e = ao;
    bus.overflow_e = ovf; bus.a3_e = a3; bus.exccode_e = exc; bus.bd_e = bd;
    bus.rt_data_e = $urandom;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h21, 6'h25, 6'h20, 6'h2B, 6'h29, 6'h28};
    logic [5:0] fns [4]  = '{6'h20, 6'h21, 6'h22, 6'h23};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    w[31:26] = ops[$urandom_range(0, 9)];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 3)];
    return w;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    reset = 1'b0;
    bus.stall_m = 0;
    bus.flush_m = 0;
    drive(1, 32'h0022_1820, 32'h0000_1234, 32'h5, 1, 5'd3, 5'd0, 1);

    // Reset held two cycles, even with live inputs.
    cycle();
    cycle();
    chk("rst_pc", bus.pc_m, 32'h0000_3000);
    chk("rst_valid", {31'd0, bus.valid_m}, 32'd0);
    chk("rst_instr", bus.instr_m, 32'd0);
    reset = 1'b1;

    // add $3,$1,$2 with overflow -> Ov, write-back killed.
    drive(1, 32'h0022_1820, 32'h0000_3000, 32'h8000_0000, 1, 5'd3, 5'd0, 0);
    cycle();
    chk("add_ov_exc", {27'd0, bus.exccode_m}, 32'd12);
    chk("add_ov_a3", {27'd0, bus.a3_m}, 32'd0);
    chk("add_ov_valid", {31'd0, bus.valid_m}, 32'd1);

    // Misaligned lw -> AdEL, address preserved.
    drive(1, 32'h8C22_0000, 32'h0000_3004, 32'h0000_0002, 0, 5'd2, 5'd0, 0);
    cycle();
    chk("lw_mis_exc", {27'd0, bus.exccode_m}, 32'd4);
    chk("lw_mis_a3", {27'd0, bus.a3_m}, 32'd0);
    chk("lw_mis_ao", bus.ao_m, 32'd2);

    // Misaligned sh -> AdES.
    drive(1, 32'hA422_0000, 32'h0000_3008, 32'h0000_0001, 0, 5'd2, 5'd0, 0);
    cycle();
    chk("sh_mis_exc", {27'd0, bus.exccode_m}, 32'd5);

    // Upstream RI beats local Ov.
    drive(1, 32'h0022_1820, 32'h0000_300C, 32'h0, 1, 5'd3, 5'd10, 0);
    cycle();
    chk("upstream_exc", {27'd0, bus.exccode_m}, 32'd10);

    // addu loaded, then held through three stalls with changing inputs.
    drive(1, 32'h0022_2821, 32'h0000_3010, 32'h77, 0, 5'd5, 5'd0, 0);
    cycle();
    bus.stall_m = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_instr(), $urandom, $urandom, 1'($urandom), 5'($urandom), 5'($urandom), 1);
      cycle();
      chk("stall_hold_instr", bus.instr_m, 32'h0022_2821);
      chk("stall_hold_a3", {27'd0, bus.a3_m}, 32'd5);
    end
    bus.flush_m = 1;
    cycle();
    chk("flush_instr", bus.instr_m, 32'd0);
    chk("flush_pc", bus.pc_m, 32'h0000_3000);
    chk("flush_valid", {31'd0, bus.valid_m}, 32'd0);
    bus.stall_m = 0;
    bus.flush_m = 0;

    // Bubble keeps pc/bd.
    drive(0, 32'h0022_1820, 32'h0000_3010, 32'h0, 1, 5'd3, 5'd0, 1);
    cycle();
    chk("bub_instr", bus.instr_m, 32'd0);
    chk("bub_valid", {31'd0, bus.valid_m}, 32'd0);
    chk("bub_pc", bus.pc_m, 32'h0000_3010);
    chk("bub_bd", {31'd0, bus.bd_m}, 32'd1);

    // addiu never raises Ov.
    drive(1, 32'h2422_0000, 32'h0000_3014, 32'h8000_0000, 1, 5'd7, 5'd0, 0);
    cycle();
    chk("addiu_exc", {27'd0, bus.exccode_m}, 32'd0);
    chk("addiu_a3", {27'd0, bus.a3_m}, 32'd7);

    // Randomized traffic, including reset during stall/flush.
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 39) != 0);
      bus.flush_m = ($urandom_range(0, 11) == 0);
      bus.stall_m = ($urandom_range(0, 4) == 0);
      drive(($urandom_range(0, 7) != 0), rand_instr(), $urandom,
            {$urandom_range(0, 1) ? 30'($urandom) : 30'd0, 2'($urandom)},
            ($urandom_range(0, 3) == 0), 5'($urandom),
            ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            1'($urandom));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
